// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared block geometry and FSM encodings for the AES byte adapter
package aes_pkg;

  localparam int BLOCK_W   = 128;
  localparam int NUM_BYTES = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    S_RX         = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_TX         = 3'd4
  } state_e;

endpackage

// File: rtl/aes_byte_stream_adapter.sv
// rtl/aes_byte_stream_adapter.sv - packs 16 input bytes into an AES block, runs the core, streams the result MSB-first
module aes_byte_stream_adapter
  import aes_pkg::*;
#(
  parameter int START_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid_i,
  input  logic [7:0]         s_data_i,
  input  logic               s_dec_i,
  output logic               s_ready_o,
  output logic               core_load_o,
  output logic [BLOCK_W-1:0] core_data_o,
  output logic               core_dec_o,
  input  logic [BLOCK_W-1:0] core_data_i,
  input  logic               core_busy_i,
  output logic               m_valid_o,
  output logic [7:0]         m_data_o,
  input  logic               m_ready_i,
  output logic               trigger_o,
  output logic               err_o
);

  localparam int TMR_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic               dec_q, dec_d;
  logic [BLOCK_W-1:0] tx_q, tx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX;
      cnt_q   <= '0;
      blk_q   <= '0;
      dec_q   <= 1'b0;
      tx_q    <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      dec_q   <= dec_d;
      tx_q    <= tx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    dec_d   = dec_q;
    tx_d    = tx_q;
    timer_d = timer_q;
    err_d   = 1'b0;

    case (state_q)
      S_RX: begin
        if (s_valid_i) begin
          // First byte lands in the MSB so the block reads in stream order
          blk_d[(BLOCK_W - 1) - 8 * int'(cnt_q) -: 8] = s_data_i;
          if (cnt_q == '0) begin
            dec_d = s_dec_i;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        timer_d = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (core_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TMR_LAST) begin
          // Core never started: drop the block, counter is already back at 0
          err_d   = 1'b1;
          state_d = S_RX;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!core_busy_i) begin
          tx_d    = core_data_i;
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (m_ready_i) begin
          tx_d  = {tx_q[BLOCK_W-9:0], 8'h00};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_RX;
          end
        end
      end
      default: begin
        state_d = S_RX;
      end
    endcase
  end

  assign s_ready_o   = (state_q == S_RX);
  assign core_load_o = (state_q == S_LOAD);
  assign core_data_o = blk_q;
  assign core_dec_o  = dec_q;
  assign m_valid_o   = (state_q == S_TX);
  assign m_data_o    = tx_q[BLOCK_W-1 -: 8];
  assign trigger_o   = (state_q == S_LOAD) || (state_q == S_WAIT_START) ||
                       (state_q == S_WAIT_DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_byte_stream_adapter.sv
// tb/tb_aes_byte_stream_adapter.sv - directed vector bench with a behavioural core model
module tb_aes_byte_stream_adapter;

  localparam int T = 8;
  localparam logic [127:0] KEY = 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;

  logic         clk;
  logic         rst_n;
  logic         s_valid_i;
  logic [7:0]   s_data_i;
  logic         s_dec_i;
  logic         s_ready_o;
  logic         core_load_o;
  logic [127:0] core_data_o;
  logic         core_dec_o;
  logic [127:0] core_data_i;
  logic         core_busy_i;
  logic         m_valid_o;
  logic [7:0]   m_data_o;
  logic         m_ready_i;
  logic         trigger_o;
  logic         err_o;

  aes_byte_stream_adapter #(.START_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_dec_i     (s_dec_i),
    .s_ready_o   (s_ready_o),
    .core_load_o (core_load_o),
    .core_data_o (core_data_o),
    .core_dec_o  (core_dec_o),
    .core_data_i (core_data_i),
    .core_busy_i (core_busy_i),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_ready_i   (m_ready_i),
    .trigger_o   (trigger_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           busy;
    logic         dec;
    logic         stall;
    logic [127:0] blk;
  } vec_t;

  vec_t vec [4];

  int           n_checks = 0;
  int           n_pass   = 0;
  int           busy_len = 1;
  logic         core_en  = 1'b1;
  int           busy_cnt = 0;
  int           load_total = 0;
  logic [127:0] ld_data  = '0;
  logic         ld_dec   = 1'b0;
  logic [127:0] res_q    = '0;

  // Core model: result is the loaded block XOR KEY, busy for busy_len cycles
  always @(posedge clk) begin
    if (core_load_o) begin
      load_total <= load_total + 1;
      ld_data    <= core_data_o;
      ld_dec     <= core_dec_o;
      res_q      <= core_data_o ^ KEY;
      busy_cnt   <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign core_busy_i = core_en && (busy_cnt != 0);
  assign core_data_i = res_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int idx);
    int guard;
    logic [127:0] blk;
    blk = vec[idx].blk;
    for (int i = 0; i < 16; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = blk[127 - 8 * i -: 8];
      s_dec_i   = (i == 0) ? vec[idx].dec : ~vec[idx].dec;
      guard = 0;
      while (!s_ready_o && guard < 100) begin
        step();
        guard++;
      end
      if (!s_ready_o) chk("rx_ready_timeout", 0, 1);
      step();
    end
    // Keep offering junk while the block is in flight; it must be ignored
    s_data_i = 8'hee;
    s_dec_i  = 1'b1;
  endtask

  task automatic run_block(input int idx, input int stop_at);
    logic [127:0] exp_res;
    int lat, k, guard, rdy_bad, base;
    exp_res  = vec[idx].blk ^ KEY;
    busy_len = vec[idx].busy;
    core_en  = 1'b1;
    base     = load_total;
    send_block(idx);
    chk("load_pulse", core_load_o, 1);
    chk("trigger_in_load", trigger_o, 1);
    lat = 1;
    rdy_bad = 0;
    while (!m_valid_o && lat < 300) begin
      if (s_ready_o || !trigger_o) rdy_bad++;
      step();
      lat++;
    end
    s_valid_i = 1'b0;
    chk("busy_phase_ready_trigger", rdy_bad, 0);
    chk("latency", lat, vec[idx].busy + 3);
    chk("load_count", load_total - base, 1);
    chk("load_data", ld_data, vec[idx].blk);
    chk("load_dec", ld_dec, vec[idx].dec);
    k = 0;
    guard = 0;
    while (k < stop_at && guard < 400) begin
      m_ready_i = vec[idx].stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_valid_o) chk("tx_valid", 0, 1);
      else chk("tx_byte", m_data_o, exp_res[127 - 8 * k -: 8]);
      if (m_valid_o && m_ready_i) k++;
      step();
      guard++;
    end
    m_ready_i = 1'b0;
    chk("tx_count", k, stop_at);
    if (stop_at == 16) begin
      chk("rx_after_tx", s_ready_o, 1);
      chk("tx_idle_after_tx", m_valid_o, 0);
    end
  endtask

  initial begin
    int n;
    vec[0] = '{busy: 45, dec: 1'b0, stall: 1'b0, blk: 128'h00112233_44556677_8899aabb_ccddeeff};
    vec[1] = '{busy: 5,  dec: 1'b1, stall: 1'b1, blk: 128'h01020304_05060708_090a0b0c_0d0e0f10};
    vec[2] = '{busy: 1,  dec: 1'b0, stall: 1'b1, blk: 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff};
    vec[3] = '{busy: 2,  dec: 1'b1, stall: 1'b0, blk: 128'hdeadbeef_01234567_89abcdef_fedcba98};

    rst_n     = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_dec_i   = 1'b0;
    m_ready_i = 1'b0;
    #2;
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_load", core_load_o, 0);
    chk("rst_trigger", trigger_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_core_data", core_data_o, 0);
    chk("rst_core_dec", core_dec_o, 0);
    #10;
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      run_block(v, 16);
    end

    // Start timeout: core never raises busy
    core_en = 1'b0;
    send_block(3);
    s_valid_i = 1'b0;
    chk("to_load_pulse", core_load_o, 1);
    n = 0;
    while (!err_o && n < 60) begin
      step();
      n++;
    end
    chk("err_delay", n, T + 1);
    chk("err_ready", s_ready_o, 1);
    chk("err_no_tx", m_valid_o, 0);
    step();
    chk("err_pulse_width", err_o, 0);
    core_en = 1'b1;

    // Reset in the middle of transmission, then a clean block
    run_block(2, 8);
    rst_n = 1'b0;
    #1;
    chk("midtx_rst_m_valid", m_valid_o, 0);
    chk("midtx_rst_s_ready", s_ready_o, 1);
    chk("midtx_rst_core_data", core_data_o, 0);
    chk("midtx_rst_trigger", trigger_o, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", s_ready_o, 1);
    run_block(0, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_byte_stream_adapter.md
AES_BYTE_STREAM_ADAPTER -- requirements
Module: aes_byte_stream_adapter

Interface
REQ-001 SHALL have parameter START_TIMEOUT, default 8, meaning the maximum number of cycles to wait for core_busy_i to rise after a load pulse.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port s_valid_i, input, 1: an input byte is offered.
REQ-005 SHALL have port s_data_i, input, 8: the input byte.
REQ-006 SHALL have port s_dec_i, input, 1: the decrypt flag, sampled with byte 0 of each block.
REQ-007 SHALL have port s_ready_o, output, 1: the adapter accepts an input byte.
REQ-008 SHALL have port core_load_o, output, 1: load strobe to the AES core.
REQ-009 SHALL have port core_data_o, output, 128: the assembled block to the core.
REQ-010 SHALL have port core_dec_o, output, 1: the decrypt flag to the core.
REQ-011 SHALL have port core_data_i, input, 128: the core result.
REQ-012 SHALL have port core_busy_i, input, 1: the core busy flag.
REQ-013 SHALL have port m_valid_o, output, 1: an output byte is offered.
REQ-014 SHALL have port m_data_o, output, 8: the output byte.
REQ-015 SHALL have port m_ready_i, input, 1: the sink accepts the output byte.
REQ-016 SHALL have port trigger_o, output, 1: scope trigger, high while a block is in the core.
REQ-017 SHALL have port err_o, output, 1: one-cycle pulse on start timeout.

Function
REQ-018 SHALL implement the states S_RX, S_LOAD, S_WAIT_START, S_WAIT_DONE and S_TX.
REQ-019 In S_RX, s_ready_o SHALL be 1, and a byte SHALL be accepted on any cycle where s_valid_i and s_ready_o are both 1.
REQ-020 Byte k (k = 0..15) SHALL be written to core_data_o[127-8k -: 8], so the first byte is the MSB.
REQ-021 s_dec_i SHALL be latched into core_dec_o only when byte 0 is accepted.
REQ-022 A 4-bit byte counter SHALL increment on each accept; the accept of byte 15 SHALL wrap it to 0 and move the FSM to S_LOAD.
REQ-023 S_LOAD SHALL last exactly 1 cycle with core_load_o = 1, then move to S_WAIT_START; core_load_o SHALL be 0 in every other state.
REQ-024 core_data_o and core_dec_o SHALL remain stable from the accept of byte 15 until the next byte-0 accept.
REQ-025 S_WAIT_START SHALL move to S_WAIT_DONE on the first cycle core_busy_i = 1.
REQ-026 If core_busy_i stays 0 for START_TIMEOUT cycles in S_WAIT_START, the block SHALL pulse err_o for 1 cycle and return to S_RX, discarding the block.
REQ-027 In S_WAIT_DONE, the first cycle with core_busy_i = 0 SHALL capture core_data_i into the tx shift register and move to S_TX.
REQ-028 In S_TX, m_valid_o SHALL be 1 and m_data_o SHALL equal tx[127:120].
REQ-029 On each cycle with m_valid_o and m_ready_i both 1, the tx register SHALL shift left by 8 and the counter SHALL increment.
REQ-030 After byte 15 is accepted, the FSM SHALL return to S_RX on the next cycle with the counter at 0.
REQ-031 m_data_o SHALL remain stable while m_valid_o = 1 and m_ready_i = 0.
REQ-032 trigger_o SHALL be 1 in S_LOAD, S_WAIT_START and S_WAIT_DONE, and 0 otherwise.
REQ-033 s_ready_o SHALL be 0 in every state except S_RX; input bytes offered outside S_RX SHALL be ignored.
REQ-034 Latency from the accept of byte 15 to m_valid_o = 1 SHALL be the core busy duration plus 3 cycles.

Reset
REQ-035 On rst_n = 0, asynchronously: the FSM SHALL enter S_RX; the counter, tx register, core_data_o, core_dec_o and err_o SHALL be 0; core_load_o, m_valid_o and trigger_o SHALL be 0.
REQ-036 A reset during any state SHALL discard any partial block; after reset, s_ready_o SHALL be 1 on the first clock.

Structure
REQ-037 State encodings, the block width (128) and the byte count (16) SHALL live in the shared package aes_pkg.
REQ-038 The block SHALL be a single module with no sub-modules; the core is instantiated by the parent.

Verification
REQ-039 With the core model (busy 45 cycles), stream bytes 00..ff (00,11,...,ff), dec = 0 -> a single core_load_o pulse, core_data_o = 128'h00112233445566778899aabbccddeeff, and the core result emitted MSB-first as 16 bytes.
REQ-040 With s_dec_i = 1 on byte 0 and 0 afterwards -> core_dec_o = 1 at load.
REQ-041 With core_busy_i tied to 0 -> err_o pulses exactly START_TIMEOUT+1 cycles after core_load_o, then s_ready_o = 1.
REQ-042 With m_ready_i toggled randomly (stalls) -> all 16 output bytes in order, none dropped or duplicated.
REQ-043 Assert rst_n = 0 mid-S_TX after byte 7 -> m_valid_o goes to 0 immediately; the next full block is processed correctly.
REQ-044 With s_valid_i held high during S_WAIT_DONE -> no bytes are accepted, and the counter stays 0.
